// File: rtl/dbus_responder.sv
// Data-bus responder for the core's MEM-stage ram_* port.
// Sequences async-SRAM strobes and UART register accesses, returns data with ack.
module dbus_responder #(
  parameter int          SRAM_AW        = 20,
  parameter logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8,
  parameter logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  input  logic [3:0]         sel_i,
  output logic [31:0]        rdata_o,
  output logic               ack_o,
  output logic               busy_o,
  output logic               unmapped_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  input  logic [31:0]        sram_rdata_i,
  output logic               sram_oe_data_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [3:0]         sram_be_n_o,
  output logic               uart_tx_start_o,
  output logic [7:0]         uart_tx_data_o,
  input  logic               uart_tx_busy_i,
  input  logic               uart_rx_ready_i,
  input  logic [7:0]         uart_rx_data_i,
  output logic               uart_rx_clear_o
);

  localparam logic [31:0] SRAM_BASE = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_RD2, S_WR1,
    S_WR2, S_WR3, S_TXW, S_ACK
  } state_e;

  state_e state_q, state_d;

  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ack_q, ack_d;
  logic               unm_q, unm_d;
  logic               rxclr_q, rxclr_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic [3:0]         be_n_q, be_n_d;
  logic               oed_q, oed_d;

  logic hit_sram, hit_data, hit_stat;

  assign hit_sram = (addr_i[31:SRAM_AW+2] == SRAM_BASE[31:SRAM_AW+2]);
  assign hit_data = (addr_i == UART_DATA_ADDR);
  assign hit_stat = (addr_i == UART_STAT_ADDR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    unm_d   = 1'b0;
    rxclr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ce_i) begin
          addr_d  = addr_i[SRAM_AW+1:2];
          wdata_d = wdata_i;
          sel_d   = sel_i;
          if (hit_sram) begin
            state_d = we_i ? S_WR1 : S_RD1;
          end else if (hit_data && we_i) begin
            state_d = S_TXW;
          end else begin
            // Single-cycle accesses: result is ready at acceptance.
            state_d = S_ACK;
            if (hit_data) begin
              rdata_d = {24'b0, uart_rx_data_i};
              rxclr_d = 1'b1;
            end else if (hit_stat) begin
              if (!we_i) begin
                rdata_d = {30'b0, uart_rx_ready_i, ~uart_tx_busy_i};
              end
            end else begin
              rdata_d = '0;
              unm_d   = 1'b1;
            end
          end
        end
      end
      S_RD1: state_d = S_RD2;
      S_RD2: begin
        rdata_d = sram_rdata_i;
        state_d = S_ACK;
      end
      S_WR1: state_d = S_WR2;
      S_WR2: state_d = S_WR3;
      S_WR3: state_d = S_ACK;
      S_TXW: begin
        if (!uart_tx_busy_i) begin
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they are glitch-free.
    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    be_n_d = 4'hF;
    oed_d  = 1'b0;
    case (state_d)
      S_RD1, S_RD2: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        be_n_d = 4'h0;
      end
      S_WR1, S_WR3: begin
        ce_n_d = 1'b0;
        oed_d  = 1'b1;
        be_n_d = ~sel_d;
      end
      S_WR2: begin
        ce_n_d = 1'b0;
        oed_d  = 1'b1;
        we_n_d = 1'b0;
        be_n_d = ~sel_d;
      end
      default: ;
    endcase
    ack_d = (state_d == S_ACK);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      unm_q   <= 1'b0;
      rxclr_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'hF;
      oed_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      unm_q   <= unm_d;
      rxclr_q <= rxclr_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      oed_q   <= oed_d;
    end
  end

  assign rdata_o         = rdata_q;
  assign ack_o           = ack_q;
  assign busy_o          = ce_i & ~ack_q;
  assign unmapped_o      = unm_q;
  assign sram_addr_o     = addr_q;
  assign sram_wdata_o    = wdata_q;
  assign sram_oe_data_o  = oed_q;
  assign sram_ce_n_o     = ce_n_q;
  assign sram_oe_n_o     = oe_n_q;
  assign sram_we_n_o     = we_n_q;
  assign sram_be_n_o     = be_n_q;
  assign uart_tx_start_o = (state_q == S_TXW) & ~uart_tx_busy_i;
  assign uart_tx_data_o  = wdata_q[7:0];
  assign uart_rx_clear_o = rxclr_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Self-checking bench for dbus_responder.
// Table of requests plus reset sequences; expectations go through a queue.
module tb_dbus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  sel_i;
  logic [31:0] rdata_o;
  logic        ack_o, busy_o, unmapped_o;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_wdata_o, sram_rdata_i;
  logic        sram_oe_data_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [3:0]  sram_be_n_o;
  logic        uart_tx_start_o;
  logic [7:0]  uart_tx_data_o;
  logic        uart_tx_busy_i, uart_rx_ready_i;
  logic [7:0]  uart_rx_data_i;
  logic        uart_rx_clear_o;

  dbus_responder dut (
    .clk(clk), .rst(rst),
    .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .sel_i(sel_i),
    .rdata_o(rdata_o), .ack_o(ack_o), .busy_o(busy_o),
    .unmapped_o(unmapped_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o),
    .sram_rdata_i(sram_rdata_i), .sram_oe_data_o(sram_oe_data_o),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
    .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o),
    .uart_tx_start_o(uart_tx_start_o), .uart_tx_data_o(uart_tx_data_o),
    .uart_tx_busy_i(uart_tx_busy_i), .uart_rx_ready_i(uart_rx_ready_i),
    .uart_rx_data_i(uart_rx_data_i), .uart_rx_clear_o(uart_rx_clear_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"},
        64'({rdata_o, ack_o, unmapped_o, sram_ce_n_o, sram_oe_n_o,
             sram_we_n_o, sram_be_n_o, sram_oe_data_o, uart_tx_start_o,
             uart_tx_data_o, uart_rx_clear_o}),
        64'({32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0,
             8'h0, 1'b0}));
    chk({nm, "_addr_data"}, 64'({sram_addr_o, sram_wdata_o}), 64'h0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        rx_ready;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic [31:0] sram_val;
    int          busy_cycles;
    int          lat;
    logic [31:0] rdata;
    logic        unm;
    int          rxclr;
    int          txcnt;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        unm;
    int          rxclr;
    int          txcnt;
    logic [7:0]  txdata;
    int          ce_c;
    int          oe_c;
    int          we_c;
    int          oed_c;
    logic [3:0]  be_n;
    logic [19:0] saddr;
    logic [31:0] wdata;
    logic        wr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_rd = 32'h0;

  function automatic vec_t mk(
    input logic we, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [3:0] sel, input logic rx_ready, input logic tx_busy,
    input logic [7:0] rx_data, input logic [31:0] sram_val,
    input int busy_cycles, input int lat, input logic [31:0] rdata,
    input logic unm, input int rxclr, input int txcnt);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel;
    v.rx_ready = rx_ready; v.tx_busy = tx_busy; v.rx_data = rx_data;
    v.sram_val = sram_val; v.busy_cycles = busy_cycles; v.lat = lat;
    v.rdata = rdata; v.unm = unm; v.rxclr = rxclr; v.txcnt = txcnt;
    return v;
  endfunction

  task automatic run(input string nm, input vec_t v);
    exp_t e;
    logic sram;
    int   ce_c, oe_c, we_c, oed_c, tx_c, rxc_c, unm_c, bad_c, busy_bad;
    int   lat;
    logic got_ack, unm_at;
    logic [31:0] rd;
    logic [7:0]  txd;

    sram     = (v.addr[31:22] == 10'h200);
    e.lat    = v.lat;
    e.unm    = v.unm;
    e.rxclr  = v.rxclr;
    e.txcnt  = v.txcnt;
    e.txdata = v.wdata[7:0];
    e.wr     = v.we;
    e.saddr  = v.addr[21:2];
    e.wdata  = v.wdata;
    e.ce_c   = sram ? (v.we ? 3 : 2) : 0;
    e.oe_c   = (sram && !v.we) ? 2 : 0;
    e.we_c   = (sram && v.we) ? 1 : 0;
    e.oed_c  = (sram && v.we) ? 3 : 0;
    e.be_n   = v.we ? ~v.sel : 4'h0;
    if (!v.we || v.unm) last_rd = v.rdata;
    e.rdata  = last_rd;
    sb_q.push_back(e);

    ce_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata;
    sel_i = v.sel; uart_rx_ready_i = v.rx_ready;
    uart_rx_data_i = v.rx_data; sram_rdata_i = v.sram_val;
    uart_tx_busy_i = (v.busy_cycles > 0) ? 1'b1 : v.tx_busy;

    ce_c = 0; oe_c = 0; we_c = 0; oed_c = 0; tx_c = 0;
    rxc_c = 0; unm_c = 0; bad_c = 0; busy_bad = 0;
    lat = -1; got_ack = 1'b0; unm_at = 1'b0; rd = '0; txd = '0;

    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!sram_ce_n_o) begin
        ce_c++;
        if (sram_addr_o !== e.saddr || sram_be_n_o !== e.be_n ||
            (e.wr && sram_wdata_o !== e.wdata))
          bad_c++;
      end
      if (!sram_oe_n_o) oe_c++;
      if (!sram_we_n_o) we_c++;
      if (sram_oe_data_o) oed_c++;
      if (uart_tx_start_o) begin
        tx_c++;
        txd = uart_tx_data_o;
      end
      if (uart_rx_clear_o) rxc_c++;
      if (unmapped_o) unm_c++;
      if (ack_o) begin
        got_ack = 1'b1;
        lat = k;
        unm_at = unmapped_o;
        rd = rdata_o;
        if (busy_o !== 1'b0) busy_bad++;
        break;
      end else if (busy_o !== 1'b1) begin
        busy_bad++;
      end
      @(posedge clk); #1;
      if (v.busy_cycles > 0)
        uart_tx_busy_i = (k + 1 <= v.busy_cycles) ? 1'b1 : v.tx_busy;
    end

    if (!got_ack) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no ack expected ack", nm);
    end

    e = sb_q.pop_front();
    chk({nm, "_lat"},    64'(lat), 64'(e.lat));
    chk({nm, "_rdata"},  64'(rd), 64'(e.rdata));
    chk({nm, "_unm"},    64'(unm_at), 64'(e.unm));
    chk({nm, "_unm_n"},  64'(unm_c), 64'(e.unm ? 1 : 0));
    chk({nm, "_rxclr"},  64'(rxc_c), 64'(e.rxclr));
    chk({nm, "_txcnt"},  64'(tx_c), 64'(e.txcnt));
    if (e.txcnt > 0) chk({nm, "_txdata"}, 64'(txd), 64'(e.txdata));
    chk({nm, "_ce_n"},   64'(ce_c), 64'(e.ce_c));
    chk({nm, "_oe_n"},   64'(oe_c), 64'(e.oe_c));
    chk({nm, "_we_n"},   64'(we_c), 64'(e.we_c));
    chk({nm, "_oedata"}, 64'(oed_c), 64'(e.oed_c));
    chk({nm, "_hold"},   64'(bad_c), 64'h0);
    chk({nm, "_busy"},   64'(busy_bad), 64'h0);

    @(posedge clk); #1;
    ce_i = 1'b0;
    uart_tx_busy_i = 1'b0;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = mk(1, 32'h8000_0010, 32'h00AB_0000, 4'b0100, 0, 0, 8'h00,
                 32'h0, 0, 4, 32'h0, 0, 0, 0);
    tbl[1]  = mk(0, 32'h8000_0010, 32'h0, 4'hF, 0, 0, 8'h00,
                 32'h12AB_5678, 0, 3, 32'h12AB_5678, 0, 0, 0);
    tbl[2]  = mk(0, 32'hBFD0_03FC, 32'h0, 4'hF, 1, 0, 8'h00,
                 32'h0, 0, 1, 32'h3, 0, 0, 0);
    tbl[3]  = mk(0, 32'hBFD0_03FC, 32'h0, 4'hF, 0, 1, 8'h00,
                 32'h0, 0, 1, 32'h0, 0, 0, 0);
    tbl[4]  = mk(0, 32'hBFD0_03F8, 32'h0, 4'hF, 1, 0, 8'h5A,
                 32'h0, 0, 1, 32'h5A, 0, 1, 0);
    tbl[5]  = mk(0, 32'h1000_0000, 32'h0, 4'hF, 0, 0, 8'h00,
                 32'hFFFF_FFFF, 0, 1, 32'h0, 1, 0, 0);
    tbl[6]  = mk(1, 32'hBFD0_03F8, 32'h0000_0041, 4'h1, 0, 0, 8'h00,
                 32'h0, 5, 7, 32'h0, 0, 0, 1);
    tbl[7]  = mk(1, 32'hBFD0_03F8, 32'h1234_56C3, 4'h1, 0, 0, 8'h00,
                 32'h0, 0, 2, 32'h0, 0, 0, 1);
    tbl[8]  = mk(1, 32'h803F_FFFC, 32'hFFFF_FFFF, 4'hF, 0, 0, 8'h00,
                 32'h0, 0, 4, 32'h0, 0, 0, 0);
    tbl[9]  = mk(0, 32'h803F_FFFC, 32'h0, 4'hF, 0, 0, 8'h00,
                 32'hA5A5_5A5A, 0, 3, 32'hA5A5_5A5A, 0, 0, 0);
    tbl[10] = mk(0, 32'h8040_0000, 32'h0, 4'hF, 0, 0, 8'h00,
                 32'h1111_1111, 0, 1, 32'h0, 1, 0, 0);
    tbl[11] = mk(0, 32'h8000_0000, 32'h0, 4'hF, 0, 0, 8'h00,
                 32'hDEAD_BEEF, 0, 3, 32'hDEAD_BEEF, 0, 0, 0);
    tbl[12] = mk(1, 32'h0000_0004, 32'h7777_7777, 4'hF, 0, 0, 8'h00,
                 32'h0, 0, 1, 32'h0, 1, 0, 0);
    tbl[13] = mk(0, 32'hBFD0_03FC, 32'h0, 4'hF, 1, 1, 8'h00,
                 32'h0, 0, 1, 32'h2, 0, 0, 0);
    tbl[14] = mk(0, 32'h7FFF_FFFC, 32'h0, 4'hF, 0, 0, 8'h00,
                 32'h2222_2222, 0, 1, 32'h0, 1, 0, 0);
    tbl[15] = mk(1, 32'h8000_0020, 32'h0000_00EE, 4'b0001, 0, 0, 8'h00,
                 32'h0, 0, 4, 32'h0, 0, 0, 0);

    rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    sel_i = '0; sram_rdata_i = '0; uart_tx_busy_i = 1'b0;
    uart_rx_ready_i = 1'b0; uart_rx_data_i = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    chk("reset_busy", 64'(busy_o), 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset landing in the middle of an SRAM write.
    ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h8000_0040;
    wdata_i = 32'hCAFE_F00D; sel_i = 4'hF;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("wr2_we_n", 64'(sram_we_n_o), 64'h0);
    rst = 1'b0;
    ce_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("midrst_we_n", 64'(sram_we_n_o), 64'h1);
        chk_reset("midrst");
      end
      chk("midrst_ack", 64'(ack_o), 64'h0);
    end
    rst = 1'b1;
    last_rd = 32'h0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run($sformatf("v%0d", i), tbl[i]);
    end

    repeat (2) @(negedge clk);
    chk("idle_ack", 64'(ack_o), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/dbus_responder.md
# dbus_responder

Data-side bus responder that services the load/store requests issued by the CPU core's MEM stage on its `ram_*` port. It decodes each request into an external asynchronous-SRAM access or a UART register access, runs the required multi-cycle SRAM strobe sequence, and returns read data together with a one-cycle acknowledge. It drives the core's stall input (`busy_o`) so the pipeline holds the request until it completes.

## Interface
Parameters
- `SRAM_AW`, 20: SRAM word-address width; mapped window is 2^SRAM_AW words.
- `UART_DATA_ADDR`, 32'hBFD0_03F8: UART data register address.
- `UART_STAT_ADDR`, 32'hBFD0_03FC: UART status register address.

Ports
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous reset, active-low (`rst==0` at a rising edge resets).
- `ce_i`  in  1  request valid; held by the core until `ack_o`.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  write data.
- `sel_i`  in  4  byte enables; bit n = byte lane n.
- `rdata_o`  out  32  read data; valid in the `ack_o` cycle and held until the next ack.
- `ack_o`  out  1  one-cycle completion pulse.
- `busy_o`  out  1  `ce_i & ~ack_o`, combinational; stall request to the core.
- `unmapped_o`  out  1  pulses together with `ack_o` when the address is unmapped.
- `sram_addr_o`  out  SRAM_AW  word address, `addr_i[SRAM_AW+1:2]`.
- `sram_wdata_o`  out  32  SRAM write data.
- `sram_rdata_i`  in  32  SRAM read data.
- `sram_oe_data_o`  out  1  tri-state enable for the SRAM data pins (1 = drive).
- `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o`  out  1 each  SRAM strobes, active-low.
- `sram_be_n_o`  out  4  byte enables, active-low.
- `uart_tx_start_o`  out  1  one-cycle transmit pulse.
- `uart_tx_data_o`  out  8  transmit byte.
- `uart_tx_busy_i`  in  1  transmitter busy.
- `uart_rx_ready_i`  in  1  received byte available.
- `uart_rx_data_i`  in  8  received byte.
- `uart_rx_clear_o`  out  1  one-cycle pulse that consumes the received byte.

## Operation
- **Address decode** (in IDLE, when `ce_i==1`):
  - SRAM: `addr_i[31:SRAM_AW+2] == 0x8000_0000[31:SRAM_AW+2]`.
  - UART data: `addr_i == UART_DATA_ADDR`.
  - UART status: `addr_i == UART_STAT_ADDR`.
  - Anything else is unmapped.
- **Latching:** address, data, sel and we are registered at acceptance. The core keeps them stable, but the block uses only the latched copies.
- **States:** IDLE, RD1, RD2, WR1, WR2, WR3, TXW, ACK.
- **IDLE**
  - SRAM read → RD1.
  - SRAM write → WR1.
  - UART data write → TXW.
  - UART data read, status read, status write (ignored) or unmapped → ACK. `rdata_o` is loaded at the accepting edge.
- **SRAM read:** RD1 → RD2 → ACK.
  - `ce_n=0` and `oe_n=0` during RD1 and RD2; `be_n=0000` for reads.
  - `sram_rdata_i` is captured into `rdata_o` at the RD2→ACK edge.
- **SRAM write:** WR1 → WR2 → WR3 → ACK.
  - `ce_n=0` and `sram_oe_data_o=1` in all three states.
  - `we_n=0` in WR2 only; `be_n=~sel`.
- **TXW:**
  - If `uart_tx_busy_i==1`, stay in TXW.
  - Otherwise pulse `uart_tx_start_o` with `uart_tx_data_o=wdata[7:0]` and go to ACK.
- **UART reads:**
  - Data read: `rdata_o = {24'b0, uart_rx_data_i}`, and `uart_rx_clear_o` pulses in the ACK cycle.
  - Status read: `rdata_o = {30'b0, uart_rx_ready_i, ~uart_tx_busy_i}`.
- **Unmapped:** `rdata_o = 0`, no side effect, `unmapped_o=1` in the ACK cycle.
- **ACK:** `ack_o=1`, all strobes inactive, → IDLE. A new request is accepted in the following IDLE cycle.
- **Reset** (including mid-operation): state → IDLE and all outputs return to reset values. SRAM strobes go inactive at that edge, with no partial write completion.

## Timing
- **Reset values:**
  - `rdata_o=0`, `ack_o=0`, `unmapped_o=0`.
  - `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o` = 1; `sram_be_n_o=4'hF`; `sram_oe_data_o=0`.
  - `sram_addr_o`, `sram_wdata_o` = 0.
  - `uart_tx_start_o=0`, `uart_tx_data_o=0`, `uart_rx_clear_o=0`.
- **Latency** (request first seen in IDLE in cycle N):
  - SRAM read: `ack_o` in N+3.
  - SRAM write: `ack_o` in N+4.
  - UART write with transmitter idle: `uart_tx_start_o` in N+1, `ack_o` in N+2. Each busy cycle adds one.
  - UART read, status, unmapped: `ack_o` in N+1.
- **Minimum gap:** back-to-back requests are one IDLE cycle apart.
- **Strobe hold:** address and write data are stable from WR1 through WR3 (the `we_n` low pulse is enclosed by stable address and data).
- **`ce_i` deasserted mid-sequence:** not allowed by protocol. The sequence still completes and `ack_o` still pulses.

## Test plan
- **Reset:** hold `rst=0` for 3 cycles mid-WR2 → `sram_we_n_o=1` at the next edge, all outputs at reset values, state IDLE.
- **SRAM byte write then read:** write `addr 0x8000_0010`, `sel=4'b0100`, data `0x00AB_0000` → `sram_addr_o=4`, `be_n=4'b1011`, `we_n` low exactly one cycle, `ack_o` at N+4. Then read the same address with the SRAM model returning `0x12AB_5678` → `rdata_o=0x12AB_5678` and `ack_o` at N+3.
- **UART transmit with busy:** hold `uart_tx_busy_i=1` for 5 cycles, then write `0x41` to `0xBFD0_03F8` → single `uart_tx_start_o` pulse with data `0x41` after busy falls, `busy_o` high throughout until `ack_o`.
- **UART status and data:**
  - Status with `rx_ready=1`, `tx_busy=0` → `rdata_o=0x3`.
  - Data read with `rx_data=0x5A` → `rdata_o=0x5A`, with `uart_rx_clear_o` pulsing once together with `ack_o`.
- **Unmapped access:** read `0x1000_0000` → `ack_o` at N+1, `rdata_o=0`, `unmapped_o=1`, no SRAM or UART strobe.
- **Back-to-back:** SRAM write followed immediately by an SRAM read → read accepted in the IDLE cycle after the write's ACK, and no strobe overlap between the two accesses.
